// File: rtl/gf163_pkg.sv
// Shared constants, state encoding and word-slice helper for the GF(2^163) multiplier sequencer.
package gf163_pkg;

  localparam int WW          = 16;
  localparam int NW          = 11;
  localparam int TIMEOUT_DEF = 64;

  // Reduction tail x^163+x^7+x^6+x^3+1, left-aligned by 5 as the core consumes it.
  localparam logic [WW*NW-1:0] G_POLY_DEF = 176'h1920;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    WAIT,
    COLLECT
  } state_t;

  function automatic logic [WW-1:0] w(input logic [WW*NW-1:0] x, input logic [3:0] i);
    return x[i*WW +: WW];
  endfunction

endpackage

// File: rtl/gf163_word_mux.sv
// Registered 11:1 selector of one 16-bit word from a 176-bit operand; drives zero when not enabled.
module gf163_word_mux
  import gf163_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WW*NW-1:0] data,
  input  logic [3:0]       sel,
  input  logic             en,
  output logic [WW-1:0]    word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else begin
      word <= en ? w(data, sel) : '0;
    end
  end

endmodule

// File: rtl/gf163_mul_seq.sv
// Feeds operand/polynomial words into the digit-serial GF(2^163) multiplier core and gathers
// the 11 product words into res, with a watchdog that aborts if the core never answers.
module gf163_mul_seq
  import gf163_pkg::*;
#(
  parameter logic [WW*NW-1:0] G_POLY  = G_POLY_DEF,
  parameter int               TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WW*NW-1:0] a,
  input  logic [WW*NW-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WW*NW-1:0] res,
  output logic             mul_ctr,
  output logic [WW-1:0]    mul_a,
  output logic [WW-1:0]    mul_b,
  output logic [WW-1:0]    mul_g,
  input  logic [WW-1:0]    mul_p,
  input  logic             mul_ctro
);

  localparam int         TW      = $clog2(TIMEOUT + 1);
  localparam logic [3:0] K_LAST  = 4'(NW);
  localparam logic [3:0] J_FIRST = 4'(NW - 2);

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [TW-1:0]          tcnt, tcnt_nxt;
  logic                   load, capture, finish, done_nxt, err_nxt;
  logic [WW*NW-1:0]       a_sh, b_sh, g_sh;
  logic [WW*(NW-1)-1:0]   coll;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    load      = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FEED;
          cnt_nxt   = 4'd0;
          load      = 1'b1;
        end
      end
      FEED: begin
        if (cnt == K_LAST) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'd0;
          tcnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WAIT: begin
        if (mul_ctro) begin
          capture   = 1'b1;
          state_nxt = COLLECT;
          cnt_nxt   = J_FIRST;
          tcnt_nxt  = '0;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      COLLECT: begin
        if (!mul_ctro) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          capture = 1'b1;
          if (cnt == 4'd0) begin
            finish    = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus words are chosen from the next state so each FEED cycle k shows its own word;
  // on the accepting cycle the shadows are not yet loaded, so the live inputs are used.
  logic             feed_nxt, en_b, en_ag;
  logic [3:0]       sel_b, sel_ag;
  logic [WW*NW-1:0] a_src, b_src, g_src;

  assign feed_nxt = (state_nxt == FEED);
  assign en_b     = feed_nxt && (cnt_nxt != K_LAST);
  assign en_ag    = feed_nxt && (cnt_nxt != 4'd0);
  assign sel_b    = K_LAST - 4'd1 - cnt_nxt;
  assign sel_ag   = K_LAST - cnt_nxt;
  assign a_src    = (state == IDLE) ? a      : a_sh;
  assign b_src    = (state == IDLE) ? b      : b_sh;
  assign g_src    = (state == IDLE) ? G_POLY : g_sh;

  gf163_word_mux u_mux_a (.clk(clk), .rst(rst), .data(a_src), .sel(sel_ag), .en(en_ag), .word(mul_a));
  gf163_word_mux u_mux_b (.clk(clk), .rst(rst), .data(b_src), .sel(sel_b),  .en(en_b),  .word(mul_b));
  gf163_word_mux u_mux_g (.clk(clk), .rst(rst), .data(g_src), .sel(sel_ag), .en(en_ag), .word(mul_g));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      tcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      mul_ctr <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      g_sh    <= '0;
      coll    <= '0;
      res     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tcnt    <= tcnt_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
      err     <= err_nxt;
      mul_ctr <= en_ag;
      if (load) begin
        a_sh <= a;
        b_sh <= b;
        g_sh <= G_POLY;
      end
      // MSW arrives first; the 11th word completes res directly so coll holds only ten.
      if (capture) begin
        coll <= {coll[WW*(NW-2)-1:0], mul_p};
      end
      if (finish) begin
        res <= {coll, mul_p};
      end
    end
  end

endmodule

// File: tb/tb_gf163_mul_seq.sv
// Directed bench for the multiplier sequencer, with the core replaced by driven po/ctro.
module tb_gf163_mul_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [175:0] a, b, res;
  logic         busy, done, err, mul_ctr, mul_ctro;
  logic [15:0]  mul_a, mul_b, mul_g, mul_p;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gf163_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .res(res),
    .mul_ctr(mul_ctr), .mul_a(mul_a), .mul_b(mul_b), .mul_g(mul_g),
    .mul_p(mul_p), .mul_ctro(mul_ctro)
  );

  task automatic check(input string tag, input logic [175:0] got, input logic [175:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [175:0] ramp(input logic [15:0] base);
    logic [175:0] r;
    for (int i = 0; i < 11; i++) r[16*i +: 16] = base + 16'(i);
    return r;
  endfunction

  task automatic start_op(input logic [175:0] na, input logic [175:0] nb);
    a = na;
    b = nb;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Entered in the FEED k=0 cycle; leaves in the first WAIT cycle.
  task automatic feed_check(input logic [175:0] ea, input logic [175:0] eb, input bit poke);
    logic [15:0] xa, xb, xg;
    for (int k = 0; k < 12; k++) begin
      xa = 16'h0;
      xb = 16'h0;
      xg = (k == 11) ? 16'h1920 : 16'h0;
      if (k > 0)  xa = ea[16*(11-k) +: 16];
      if (k < 11) xb = eb[16*(10-k) +: 16];
      check("feed_ctr",  176'(mul_ctr), 176'(k != 0));
      check("feed_a",    176'(mul_a),   176'(xa));
      check("feed_b",    176'(mul_b),   176'(xb));
      check("feed_g",    176'(mul_g),   176'(xg));
      check("feed_busy", 176'(busy),    176'(1'b1));
      if (k == 1) begin
        a = ~a;
        b = ~b;
      end
      start = poke && (k == 3);
      tick;
    end
    start = 1'b0;
    check("wait_ctr", 176'(mul_ctr), 176'(1'b0));
    check("wait_a",   176'(mul_a),   176'(16'h0));
    check("wait_b",   176'(mul_b),   176'(16'h0));
    check("wait_g",   176'(mul_g),   176'(16'h0));
  endtask

  // Leaves in the done cycle.
  task automatic collect(input int delay, input logic [15:0] base);
    repeat (delay) tick;
    for (int i = 10; i >= 0; i--) begin
      mul_ctro = 1'b1;
      mul_p    = base + 16'(i);
      if (i == 0) check("done_early", 176'(done), 176'(1'b0));
      tick;
    end
    mul_ctro = 1'b0;
    mul_p    = 16'h0;
    check("done_pulse", 176'(done), 176'(1'b1));
    check("done_busy",  176'(busy), 176'(1'b0));
    check("done_err",   176'(err),  176'(1'b0));
    check("done_res",   res,        ramp(base));
  endtask

  initial begin
    int  cyc;
    bit  saw_err, saw_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; mul_p = '0; mul_ctro = 1'b0;
    #12;
    check("rst_busy", 176'(busy),    176'(1'b0));
    check("rst_done", 176'(done),    176'(1'b0));
    check("rst_err",  176'(err),     176'(1'b0));
    check("rst_ctr",  176'(mul_ctr), 176'(1'b0));
    check("rst_a",    176'(mul_a),   176'(16'h0));
    check("rst_b",    176'(mul_b),   176'(16'h0));
    check("rst_g",    176'(mul_g),   176'(16'h0));
    check("rst_res",  res,           176'h0);
    rst = 1'b0;
    tick;

    // Word order and collection.
    start_op(ramp(16'h0000), ramp(16'h0100));
    feed_check(ramp(16'h0000), ramp(16'h0100), 1'b0);
    collect(2, 16'hF000);
    tick;
    check("pulse_end", 176'(done), 176'(1'b0));

    // Watchdog: core never answers.
    start_op(ramp(16'h1100), ramp(16'h2200));
    feed_check(ramp(16'h1100), ramp(16'h2200), 1'b0);
    cyc = 0;
    while (!err && cyc < 200) begin
      tick;
      cyc++;
    end
    check("timeout_cycles", 176'(cyc),  176'(64));
    check("timeout_busy",   176'(busy), 176'(1'b0));
    check("timeout_res",    res,        ramp(16'hF000));
    tick;
    check("timeout_pulse",  176'(err),  176'(1'b0));

    // Core drops ctro after five words.
    start_op(ramp(16'h3300), ramp(16'h4400));
    feed_check(ramp(16'h3300), ramp(16'h4400), 1'b0);
    for (int i = 0; i < 5; i++) begin
      mul_ctro = 1'b1;
      mul_p    = 16'hAAA0 + 16'(i);
      tick;
    end
    mul_ctro = 1'b0;
    saw_err = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      saw_err  |= err;
      saw_done |= done;
    end
    check("short_err",  176'(saw_err),  176'(1'b1));
    check("short_done", 176'(saw_done), 176'(1'b0));
    check("short_res",  res,            ramp(16'hF000));
    check("short_busy", 176'(busy),     176'(1'b0));

    // Reset in the middle of FEED at k=6.
    start_op(ramp(16'h2000), ramp(16'h3000));
    repeat (6) tick;
    check("k6_ctr", 176'(mul_ctr), 176'(1'b1));
    check("k6_a",   176'(mul_a),   176'(16'h2005));
    check("k6_b",   176'(mul_b),   176'(16'h3004));
    #2 rst = 1'b1;
    #1;
    check("arst_ctr",  176'(mul_ctr), 176'(1'b0));
    check("arst_a",    176'(mul_a),   176'(16'h0));
    check("arst_b",    176'(mul_b),   176'(16'h0));
    check("arst_g",    176'(mul_g),   176'(16'h0));
    check("arst_busy", 176'(busy),    176'(1'b0));
    check("arst_res",  res,           176'h0);
    #2 rst = 1'b0;
    tick;
    check("arst_idle", 176'(busy), 176'(1'b0));
    start_op(ramp(16'h8000), ramp(16'h9000));
    feed_check(ramp(16'h8000), ramp(16'h9000), 1'b0);
    collect(0, 16'hE000);
    tick;

    // start while busy is ignored; start in the done cycle is accepted next cycle.
    start_op(ramp(16'h4000), ramp(16'h5000));
    feed_check(ramp(16'h4000), ramp(16'h5000), 1'b1);
    collect(1, 16'hD000);
    a = ramp(16'h6000);
    b = ramp(16'h7000);
    start = 1'b1;
    tick;
    start = 1'b0;
    feed_check(ramp(16'h6000), ramp(16'h7000), 1'b0);
    collect(4, 16'hC000);
    tick;
    check("b2b_done_end", 176'(done), 176'(1'b0));
    check("b2b_idle",     176'(busy), 176'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gf163_mul_seq.md
Name: gf163_mul_seq

Overview:
Sequencer for the 16-bit digit-serial GF(2^163) multiplier core (ports ctr, a_in, b_in, g_in, po, ctro). It accepts full 176-bit operands and a start pulse, and streams operand and reduction-polynomial words into the core in the required order. It then gathers the 11 product words from the core into a 176-bit result with a done pulse. A watchdog aborts the operation if the core never asserts ctro.

Parameters:
G_POLY, 176'h1920, reduction tail word image as the core expects it (x^163+x^7+x^6+x^3+1, left-aligned by 5).
NW, 11, number of 16-bit words per operand (fixed by the core; 176/16).
TIMEOUT, 64, maximum cycles in WAIT before abort.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle request; sampled only in IDLE
a  in  176  operand A, word 10 = bits 175:160 (MSW)
b  in  176  operand B, same packing
busy  out  1  high from accepted start until done/err
done  out  1  1-cycle pulse, res valid
err  out  1  1-cycle pulse on timeout; res unchanged
res  out  176  product, MSW-first assembled
mul_ctr  out  1  to core ctr
mul_a  out  16  to core a_in
mul_b  out  16  to core b_in
mul_g  out  16  to core g_in
mul_p  in  16  from core po
mul_ctro  in  1  from core ctro, high while po carries product words

Behaviour:
- Reset (async, rst=1): state IDLE. busy, done, err, mul_ctr = 0. mul_a, mul_b, mul_g = 0. res = 0. Word counter and timeout counter = 0. Reset mid-operation abandons the run with no done/err. mul_* return to 0 immediately.
- All mul_* outputs are registered. Word k counts k = 0..11 in FEED.
- IDLE: start=1 latches a, b and G_POLY into shadow regs, then goes to FEED with k=0 and busy=1. Operand changes after this have no effect.
- FEED (12 cycles):
  - k=0: ctr=0, mul_b = b.w10, mul_a = 0, mul_g = 0.
  - k=1..10: ctr=1, mul_b = b.w(10-k), mul_a = a.w(11-k), mul_g = g.w(11-k).
  - k=11: ctr=1, mul_b = 0, mul_a = a.w0, mul_g = g.w0.
  - After k=11, go to WAIT.
- WAIT: mul_ctr = 0 and mul_a/b/g = 0. Timeout counter increments each cycle.
  - First cycle with mul_ctro=1: capture mul_p as word 10, go to COLLECT with j=9.
  - Counter reaching TIMEOUT: err pulse, busy=0, go to IDLE.
- COLLECT: each cycle captures mul_p into word j and decrements j. After word 0 is captured, res is updated with all 11 words simultaneously, done=1 for 1 cycle, busy=0, go to IDLE.
  - mul_ctro dropping before 11 words: err pulse, go to IDLE, res unchanged.
- start while busy: ignored. Back-to-back: start may be asserted in the cycle done is high and is accepted in the next cycle (IDLE).
- Latency from start accept to done = 12 + wait + 11 cycles.
- No arithmetic is performed; bits 175:163 of operands pass through unchecked.

Decomposition:
- Package gf163_pkg holds:
  - NW, word width 16, G_POLY default;
  - state enum {IDLE, FEED, WAIT, COLLECT};
  - word-index function w(x,i) = x[16i+15:16i].
- Sub-module gf163_word_mux: registered 11:1 word selector used for a/b/g; instantiated 3×.
- Collection shift register stays in the top.

Test Plan:
- Word order: a = {16'h000A, …, 16'h0000} (word i = i), b word i = 16'h0100+i. Start → monitor cycles k=0..11:
  - mul_b = 010A, 0109 … 0100, 0000;
  - mul_a = 0000, 000A … 0000;
  - ctr = 0, then 1 ×11.
- Collection: mock core asserts ctro 3 cycles after FEED ends, po = 16'hF00A down to 16'hF000 → res = {F00A,…,F000}, done 1 cycle, busy falls the same cycle.
- Timeout: mock never asserts ctro → err pulse exactly TIMEOUT cycles after WAIT entry, res keeps prior value, busy=0.
- Short ctro: ctro high for only 5 cycles → err, no done, res unchanged.
- Reset mid-FEED at k=6: all outputs 0 asynchronously, state IDLE; a following start runs a full correct sequence.
- start pulsed while busy and in the done cycle: the first is ignored, the second is accepted the next cycle, with FEED k=0 exactly one cycle after the done cycle.
